// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding and defaults for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MDU  = 2'd1,
    HALT = 2'd2
  } hz_state_e;

  // Default total EX occupancy of a multi-cycle op
  localparam int MDU_CYCLES_DEF = 4;

  // Wide enough for MDU_CYCLES-2 at the largest legal MDU_CYCLES (16)
  localparam int MDU_CNT_W = 4;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect #(
  parameter int REG_AW = 4
) (
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_uses_rs2_i,
  output logic              load_use_o
);

  // Register 0 is hardwired, so a load targeting it can never create a hazard
  always_comb begin
    load_use_o = ex_mem_read_i && (ex_rd_i != '0) &&
                 ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/halt controller; HAZ_STATS_EN adds stall/flush counters
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int MDU_CYCLES = MDU_CYCLES_DEF,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic              id_mdu_op,
  input  logic              id_halt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              resume,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_nop,
  output logic              halted,
  output logic              mdu_busy
`ifdef HAZ_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
`endif
);

  hz_state_e              state_q, state_d;
  logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   load_use;

  load_use_detect #(.REG_AW(REG_AW)) u_lud (
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs2_i (id_uses_rs2),
    .load_use_o    (load_use)
  );

  // Next-state and pipeline-control decode; reset forces the free-running defaults
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_nop   = 1'b0;
    halted     = 1'b0;
    mdu_busy   = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_nop   = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_nop   = 1'b1;
        end else if (id_halt) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_nop   = 1'b1;
          state_d    = HALT;
        end else if (id_mdu_op) begin
          cnt_d   = MDU_CNT_W'(MDU_CYCLES - 2);
          state_d = MDU;
        end
      end
      MDU: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_nop   = 1'b1;
        mdu_busy   = 1'b1;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HALT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_nop   = 1'b1;
        halted     = 1'b1;
        if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    if (!rst) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_nop   = 1'b0;
      halted     = 1'b0;
      mdu_busy   = 1'b0;
    end
  end

  // State and multi-cycle countdown registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counts of front-end stall cycles and flush cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!ifid_write && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end
      if (ifid_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + STAT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int AW = 4;
  localparam int SW = 4;

  // expected vector: {pc_write, ifid_write, ifid_flush, idex_nop, halted, mdu_busy}
  localparam logic [5:0] E_RUN   = 6'b110000;
  localparam logic [5:0] E_STALL = 6'b000100;
  localparam logic [5:0] E_FLUSH = 6'b111100;
  localparam logic [5:0] E_MDU   = 6'b000101;
  localparam logic [5:0] E_HALT  = 6'b000110;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_uses_rs2 = 1'b0, id_mdu_op = 1'b0, id_halt = 1'b0;
  logic          ex_mem_read = 1'b0, ex_branch_taken = 1'b0, resume = 1'b0;
  logic          pc_write, ifid_write, ifid_flush, idex_nop, halted, mdu_busy;
`ifdef HAZ_STATS_EN
  logic [SW-1:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0] exp;
    string      nm;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .MDU_CYCLES(4), .STAT_W(SW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs2     (id_uses_rs2),
    .id_mdu_op       (id_mdu_op),
    .id_halt         (id_halt),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .resume          (resume),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_nop        (idex_nop),
    .halted          (halted),
    .mdu_busy        (mdu_busy)
`ifdef HAZ_STATS_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  // monitor: compare the DUT outputs each cycle against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [5:0] got;
      e   = sb.pop_front();
      got = {pc_write, ifid_write, ifid_flush, idex_nop, halted, mdu_busy};
      n_checks++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", e.nm, got, e.exp);
      end
    end
  end

  task automatic step(input logic r, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                      input logic u2, input logic mdu, input logic hlt, input logic mr,
                      input logic [AW-1:0] rd, input logic br, input logic res,
                      input logic [5:0] exp, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; id_mdu_op = mdu;
    id_halt = hlt; ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br; resume = res;
    e.exp = exp;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  initial begin
    // reset: defaults even with a branch presented
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_RUN,   "reset_defaults");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "idle_run");
    // load-use through rs1, one cycle only
    step(1, 3, 0, 0, 0, 0, 1, 3, 0, 0, E_STALL, "lu_rs1");
    step(1, 3, 0, 0, 0, 0, 0, 3, 0, 0, E_RUN,   "lu_released");
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_RUN,   "lu_rd0_nostall");
    // rs2 only when used
    step(1, 2, 5, 0, 0, 0, 1, 5, 0, 0, E_RUN,   "lu_rs2_unused");
    step(1, 2, 5, 1, 0, 0, 1, 5, 0, 0, E_STALL, "lu_rs2_used");
    // branch beats load-use and halt
    step(1, 3, 0, 0, 0, 1, 1, 3, 1, 0, E_FLUSH, "branch_priority");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "after_branch_run");
    // load-use beats halt
    step(1, 3, 0, 0, 0, 1, 1, 3, 0, 0, E_STALL, "lu_over_halt");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "lu_over_halt_run");
    // multi-cycle op: issue, three stall cycles (requests ignored), back to run
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, E_RUN,   "mdu_issue");
    step(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, E_MDU,   "mdu_1");
    step(1, 3, 0, 0, 1, 0, 1, 3, 0, 0, E_MDU,   "mdu_2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_MDU,   "mdu_3");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "mdu_done");
    // resume outside HALT ignored
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN,   "resume_in_run");
    // halt, held ten cycles, then resume
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, E_STALL, "halt_req");
    for (int i = 0; i < 10; i++)
      step(1, 3, 0, 0, (i == 4), 1, 1, 3, (i == 2), 0, E_HALT, "halt_hold");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_HALT,  "halt_resume_cycle");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "after_resume");
    // reset mid-HALT releases immediately
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, E_STALL, "halt_req2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HALT,  "halt2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "reset_mid_halt");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "post_reset_halt");
    // reset mid-MDU aborts it
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, E_RUN,   "mdu_issue2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_MDU,   "mdu2_1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "reset_mid_mdu");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "post_reset_mdu");
    // 20 stall cycles from a clean reset: halt request + 19 HALT cycles
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "reset_stats");
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, E_STALL, "stats_halt_req");
    for (int i = 0; i < 19; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HALT, "stats_halt");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_HALT,  "stats_resume");
`ifdef HAZ_STATS_EN
    n_checks++;
    if (stall_cnt !== 4'hF) begin
      n_fail++;
      $display("FAIL stall_cnt_sat: got %0d expected 15", stall_cnt);
    end
    n_checks++;
    if (flush_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL flush_cnt_idle: got %0d expected 0", flush_cnt);
    end
`endif
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FLUSH, "final_branch");
    @(posedge clk);
    #1;
    ex_branch_taken = 1'b0;
`ifdef HAZ_STATS_EN
    n_checks++;
    if (flush_cnt !== 4'h1) begin
      n_fail++;
      $display("FAIL flush_cnt_one: got %0d expected 1", flush_cnt);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 4, register-address width.
REQ-002 SHALL have parameter MDU_CYCLES, default 4, total EX cycles of a multi-cycle op (legal range 2..16).
REQ-003 SHALL have parameter STAT_W, default 16, statistics counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports id_rs1, id_rs2  input  REG_AW  source registers of the instruction in ID.
REQ-007 SHALL have port id_uses_rs2  input  1  ID instruction reads id_rs2.
REQ-008 SHALL have ports id_mdu_op, id_halt  input  1  ID instruction is multi-cycle / halt.
REQ-009 SHALL have ports ex_mem_read  input  1, ex_rd  input  REG_AW  load in EX and its destination.
REQ-010 SHALL have port ex_branch_taken  input  1  branch resolved taken in EX.
REQ-011 SHALL have port resume  input  1  leave halt.
REQ-012 SHALL have outputs pc_write, ifid_write, ifid_flush, idex_nop, halted, mdu_busy, each 1 bit: PC enable, IF/ID buffer enable, IF/ID buffer flush, bubble into ID/EX, halt status, multi-cycle op in progress.

Function
REQ-013 SHALL implement states RUN, MDU, HALT; outputs combinational from state and inputs.
REQ-014 RUN defaults: pc_write=1, ifid_write=1, ifid_flush=0, idex_nop=0.
REQ-015 RUN, ex_branch_taken=1 (highest priority): ifid_flush=1, idex_nop=1 same cycle; stay RUN; load-use, halt and mdu requests ignored that cycle.
REQ-016 RUN, load-use (ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | id_uses_rs2 & ex_rd==id_rs2)), no branch: pc_write=0, ifid_write=0, idex_nop=1 for that cycle; stay RUN.
REQ-017 RUN, id_halt, no branch/load-use: instruction not passed (idex_nop=1, pc_write=0, ifid_write=0); next state HALT.
REQ-018 RUN, id_mdu_op, no branch/load-use/halt: op passes to EX (idex_nop=0); counter loads MDU_CYCLES-2; next state MDU.
REQ-019 MDU: pc_write=0, ifid_write=0, idex_nop=1, mdu_busy=1; counter decrements each cycle; at counter==0 next state RUN; total stall exactly MDU_CYCLES-1 cycles.
REQ-020 HALT: pc_write=0, ifid_write=0, idex_nop=1, halted=1; resume=1 -> RUN next cycle; resume in RUN/MDU ignored.
REQ-021 ex_branch_taken, id_halt, id_mdu_op and load-use ignored in MDU and HALT.
REQ-022 ex_rd==0 never causes a stall (register 0 hardwired).

Reset
REQ-023 rst low SHALL immediately force state RUN, counter 0, statistics 0, regardless of clock.
REQ-024 During reset outputs SHALL be pc_write=1, ifid_write=1, ifid_flush=0, idex_nop=0, halted=0, mdu_busy=0.
REQ-025 Reset during MDU or HALT SHALL abort it; first post-reset cycle is RUN.

Configuration
REQ-026 Macro HAZ_STATS_EN defined: ports stall_cnt, flush_cnt (output, STAT_W) SHALL exist; stall_cnt increments every cycle ifid_write=0, flush_cnt every cycle ifid_flush=1; both saturate at all-ones.
REQ-027 HAZ_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package hazard_pkg SHALL hold the state enum (RUN, MDU, HALT) and default MDU_CYCLES constant.
REQ-029 Load-use comparison SHALL be sub-module load_use_detect (pure combinational); FSM and counter remain in pipe_hazard_ctrl.

Verification
REQ-030 Load r3 in EX (ex_mem_read=1, ex_rd=3), id_rs1=3 -> one cycle pc_write=0, ifid_write=0, idex_nop=1; with ex_rd=0 -> no stall.
REQ-031 id_uses_rs2=0, ex_rd==id_rs2=5, id_rs1=2 -> no stall; id_uses_rs2=1 -> stall.
REQ-032 ex_branch_taken=1 with concurrent load-use and id_halt -> ifid_flush=1, idex_nop=1, pc_write=1, state stays RUN.
REQ-033 id_mdu_op=1, MDU_CYCLES=4 -> idex_nop=0 that cycle, then exactly 3 cycles mdu_busy=1 with stall, then RUN.
REQ-034 id_halt=1 -> halted=1 from next cycle, held 10 cycles with resume=0; resume=1 -> RUN next cycle; rst low mid-HALT -> halted=0 immediately.
REQ-035 HAZ_STATS_EN, STAT_W=4: 20 stall cycles -> stall_cnt=15 (saturated), flush_cnt unchanged.
